// File: rtl/pipelined_divider_32.sv
// 32-bit pipelined divider built from four 8-row non-restoring array blocks; define
// DIVIDER_SIGNED_EN for two's-complement operands (quotient truncates, remainder takes dividend sign).

// 32-bit ripple adder used for the final remainder restore.
// Latency: combinational.
// Backpressure: none.
module adder_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum
);

  assign sum = a + b + {31'b0, cin};

endmodule

// Eight rows of non-restoring division: each row shifts in one dividend bit and adds/subtracts the divisor.
// Latency: combinational.
// Backpressure: none.
module array_division_block_8x32 (
  input  logic [32:0] rem_in,
  input  logic        mode_in,
  input  logic [7:0]  dvd_bits,
  input  logic [31:0] divisor,
  output logic [32:0] rem_out,
  output logic [7:0]  quo_bits
);

  // Partial remainder stays in [-divisor, divisor), so 33 bits hold it and 34 bits hold 2R+bit.
  always_comb begin
    logic [32:0] part;
    logic        mode;
    logic [33:0] trial;
    part     = rem_in;
    mode     = mode_in;
    trial    = 34'd0;
    quo_bits = 8'd0;
    for (int i = 7; i >= 0; i--) begin
      trial       = {part, dvd_bits[i]};
      trial       = mode ? trial - {2'b00, divisor} : trial + {2'b00, divisor};
      part        = trial[32:0];
      mode        = ~trial[33];
      quo_bits[i] = mode;
    end
    rem_out = part;
  end

endmodule

// Pipelined 32-bit divider, one operation accepted per clock.
// Latency: operands sampled at edge N appear on the outputs after edge N+3.
// Backpressure: none; the consumer must sample on out_valid.
module pipelined_divider_32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_dividend,
  input  logic [31:0] in_divisor,
  output logic        out_valid,
  output logic [31:0] out_quotient,
  output logic [31:0] out_remainder
);

  logic [31:0] dvd_mag;
  logic [31:0] dvs_mag;

`ifdef DIVIDER_SIGNED_EN
  logic neg_q_in;
  logic neg_r_in;
  logic s1_neg_q, s1_neg_r;
  logic s2_neg_q, s2_neg_r;
  logic s3_neg_q, s3_neg_r;

  assign dvd_mag  = in_dividend[31] ? 32'd0 - in_dividend : in_dividend;
  assign dvs_mag  = in_divisor[31]  ? 32'd0 - in_divisor  : in_divisor;
  // A zero divisor keeps the all-ones quotient whatever the dividend's sign.
  assign neg_q_in = (in_dividend[31] ^ in_divisor[31]) && (in_divisor != 32'd0);
  assign neg_r_in = in_dividend[31];
`else
  assign dvd_mag = in_dividend;
  assign dvs_mag = in_divisor;
`endif

  logic [32:0] rem1, rem2, rem3, rem4;
  logic [7:0]  quo1, quo2, quo3, quo4;

  logic        s1_vld, s1_mode;
  logic [32:0] s1_rem;
  logic [7:0]  s1_quo;
  logic [23:0] s1_dvd;
  logic [31:0] s1_dvs;

  logic        s2_vld, s2_mode;
  logic [32:0] s2_rem;
  logic [15:0] s2_quo;
  logic [15:0] s2_dvd;
  logic [31:0] s2_dvs;

  logic        s3_vld, s3_mode;
  logic [32:0] s3_rem;
  logic [23:0] s3_quo;
  logic [7:0]  s3_dvd;
  logic [31:0] s3_dvs;

  array_division_block_8x32 u_blk1 (
    .rem_in   (33'd0),
    .mode_in  (1'b1),
    .dvd_bits (dvd_mag[31:24]),
    .divisor  (dvs_mag),
    .rem_out  (rem1),
    .quo_bits (quo1)
  );

  array_division_block_8x32 u_blk2 (
    .rem_in   (s1_rem),
    .mode_in  (s1_mode),
    .dvd_bits (s1_dvd[23:16]),
    .divisor  (s1_dvs),
    .rem_out  (rem2),
    .quo_bits (quo2)
  );

  array_division_block_8x32 u_blk3 (
    .rem_in   (s2_rem),
    .mode_in  (s2_mode),
    .dvd_bits (s2_dvd[15:8]),
    .divisor  (s2_dvs),
    .rem_out  (rem3),
    .quo_bits (quo3)
  );

  array_division_block_8x32 u_blk4 (
    .rem_in   (s3_rem),
    .mode_in  (s3_mode),
    .dvd_bits (s3_dvd),
    .divisor  (s3_dvs),
    .rem_out  (rem4),
    .quo_bits (quo4)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld  <= 1'b0;
      s1_mode <= 1'b0;
      s1_rem  <= 33'd0;
      s1_quo  <= 8'd0;
      s1_dvd  <= 24'd0;
      s1_dvs  <= 32'd0;
      s2_vld  <= 1'b0;
      s2_mode <= 1'b0;
      s2_rem  <= 33'd0;
      s2_quo  <= 16'd0;
      s2_dvd  <= 16'd0;
      s2_dvs  <= 32'd0;
      s3_vld  <= 1'b0;
      s3_mode <= 1'b0;
      s3_rem  <= 33'd0;
      s3_quo  <= 24'd0;
      s3_dvd  <= 8'd0;
      s3_dvs  <= 32'd0;
    end else begin
      s1_vld <= in_valid;
      s2_vld <= s1_vld;
      s3_vld <= s2_vld;
      // Data registers only move with a live operation; bubbles leave them untouched.
      if (in_valid) begin
        s1_mode <= quo1[0];
        s1_rem  <= rem1;
        s1_quo  <= quo1;
        s1_dvd  <= dvd_mag[23:0];
        s1_dvs  <= dvs_mag;
      end
      if (s1_vld) begin
        s2_mode <= quo2[0];
        s2_rem  <= rem2;
        s2_quo  <= {s1_quo, quo2};
        s2_dvd  <= s1_dvd[15:0];
        s2_dvs  <= s1_dvs;
      end
      if (s2_vld) begin
        s3_mode <= quo3[0];
        s3_rem  <= rem3;
        s3_quo  <= {s2_quo, quo3};
        s3_dvd  <= s2_dvd[7:0];
        s3_dvs  <= s2_dvs;
      end
    end
  end

`ifdef DIVIDER_SIGNED_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_neg_q <= 1'b0;
      s1_neg_r <= 1'b0;
      s2_neg_q <= 1'b0;
      s2_neg_r <= 1'b0;
      s3_neg_q <= 1'b0;
      s3_neg_r <= 1'b0;
    end else begin
      s1_neg_q <= neg_q_in;
      s1_neg_r <= neg_r_in;
      s2_neg_q <= s1_neg_q;
      s2_neg_r <= s1_neg_r;
      s3_neg_q <= s2_neg_q;
      s3_neg_r <= s2_neg_r;
    end
  end
`endif

  logic [31:0] rem_restored;
  logic [31:0] quo_mag;
  logic [31:0] rem_mag;
  logic [31:0] quo_res;
  logic [31:0] rem_res;

  adder_32 u_restore (
    .a   (rem4[31:0]),
    .b   (s3_dvs),
    .cin (1'b0),
    .sum (rem_restored)
  );

  // The final partial is negative exactly when the last quotient bit is 0.
  assign quo_mag = {s3_quo, quo4};
  assign rem_mag = rem4[32] ? rem_restored : rem4[31:0];

`ifdef DIVIDER_SIGNED_EN
  assign quo_res = s3_neg_q ? 32'd0 - quo_mag : quo_mag;
  assign rem_res = s3_neg_r ? 32'd0 - rem_mag : rem_mag;
`else
  assign quo_res = quo_mag;
  assign rem_res = rem_mag;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_quotient  <= 32'd0;
      out_remainder <= 32'd0;
    end else begin
      out_valid <= s3_vld;
      if (s3_vld) begin
        out_quotient  <= quo_res;
        out_remainder <= rem_res;
      end
    end
  end

endmodule

// File: tb/tb_pipelined_divider_32.sv
// Directed bench for pipelined_divider_32: reset, latency, back-to-back issue, boundaries, bubbles.
// Signed vectors are exercised when DIVIDER_SIGNED_EN is defined.

module tb_pipelined_divider_32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_dividend = 32'd0;
  logic [31:0] in_divisor = 32'd0;
  logic        out_valid;
  logic [31:0] out_quotient;
  logic [31:0] out_remainder;

  int checks = 0;
  int passed = 0;

  pipelined_divider_32 dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_dividend   (in_dividend),
    .in_divisor    (in_divisor),
    .out_valid     (out_valid),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

  task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] b);
    in_valid    = v;
    in_dividend = a;
    in_divisor  = b;
  endtask

  task automatic test_reset_state();
    rst_n = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_vld: got %b want 0", out_valid); else passed++;
    checks++; if (out_quotient !== 32'd0) $display("FAIL rst_q: got %h want 0", out_quotient); else passed++;
    checks++; if (out_remainder !== 32'd0) $display("FAIL rst_r: got %h want 0", out_remainder); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL rst_release_vld: got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_basic();
    for (int c = 0; c <= 8; c++) begin
      @(negedge clk);
      if (c == 3 || c == 5 || c == 7) begin
        checks++; if (out_valid !== 1'b0) $display("FAIL basic_idle_vld[c%0d]: got %b want 0", c, out_valid); else passed++;
      end
      if (c == 4) begin
        checks++; if (out_valid !== 1'b1) $display("FAIL basic0_vld: got %b want 1", out_valid); else passed++;
        checks++; if (out_quotient !== 32'd7) $display("FAIL basic0_q: got %h want %h", out_quotient, 32'd7); else passed++;
        checks++; if (out_remainder !== 32'd2) $display("FAIL basic0_r: got %h want %h", out_remainder, 32'd2); else passed++;
      end
      if (c == 8) begin
        checks++; if (out_valid !== 1'b1) $display("FAIL basic1_vld: got %b want 1", out_valid); else passed++;
        checks++; if (out_quotient !== 32'd10) $display("FAIL basic1_q: got %h want %h", out_quotient, 32'd10); else passed++;
        checks++; if (out_remainder !== 32'd0) $display("FAIL basic1_r: got %h want %h", out_remainder, 32'd0); else passed++;
      end
      if (c == 0) drive(1'b1, 32'h1E, 32'h4);
      else if (c == 4) drive(1'b1, 32'hA, 32'h1);
      else drive(1'b0, 32'd0, 32'd0);
    end
  endtask

`ifndef DIVIDER_SIGNED_EN
  task automatic test_pipelined();
    logic [31:0] a [4];
    logic [31:0] b [4];
    logic [31:0] eq [4];
    logic [31:0] er [4];
    a  = '{32'hFFFFFFFF, 32'd100, 32'd0, 32'h12345678};
    b  = '{32'h10, 32'd7, 32'd5, 32'h1};
    eq = '{32'h0FFFFFFF, 32'd14, 32'd0, 32'h12345678};
    er = '{32'hF, 32'd2, 32'd0, 32'd0};
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c >= 4) begin
        checks++; if (out_valid !== 1'b1) $display("FAIL pipe_vld[%0d]: got %b want 1", c - 4, out_valid); else passed++;
        checks++; if (out_quotient !== eq[c-4]) $display("FAIL pipe_q[%0d]: got %h want %h", c - 4, out_quotient, eq[c-4]); else passed++;
        checks++; if (out_remainder !== er[c-4]) $display("FAIL pipe_r[%0d]: got %h want %h", c - 4, out_remainder, er[c-4]); else passed++;
      end
      if (c < 4) drive(1'b1, a[c], b[c]);
      else drive(1'b0, 32'd0, 32'd0);
    end
  endtask

  task automatic test_boundary();
    logic [31:0] a [6];
    logic [31:0] b [6];
    logic [31:0] eq [6];
    logic [31:0] er [6];
    a  = '{32'd5, 32'hFFFFFFFF, 32'h80000000, 32'd7, 32'd0, 32'hFFFFFFFF};
    b  = '{32'd9, 32'hFFFFFFFF, 32'h2, 32'd0, 32'd0, 32'h1};
    eq = '{32'd0, 32'd1, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    er = '{32'd5, 32'd0, 32'd0, 32'd7, 32'd0, 32'd0};
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c >= 4) begin
        checks++; if (out_valid !== 1'b1) $display("FAIL bound_vld[%0d]: got %b want 1", c - 4, out_valid); else passed++;
        checks++; if (out_quotient !== eq[c-4]) $display("FAIL bound_q[%0d]: got %h want %h", c - 4, out_quotient, eq[c-4]); else passed++;
        checks++; if (out_remainder !== er[c-4]) $display("FAIL bound_r[%0d]: got %h want %h", c - 4, out_remainder, er[c-4]); else passed++;
      end
      if (c < 6) drive(1'b1, a[c], b[c]);
      else drive(1'b0, 32'd0, 32'd0);
    end
  endtask
`else
  task automatic test_signed();
    logic [31:0] a [5];
    logic [31:0] b [5];
    logic [31:0] eq [5];
    logic [31:0] er [5];
    // 10/-3, -500/3, -100/-9, 0x80000000/-1, -7/0
    a  = '{32'd10, 32'hFFFFFE0C, 32'hFFFFFF9C, 32'h80000000, 32'hFFFFFFF9};
    b  = '{32'hFFFFFFFD, 32'd3, 32'hFFFFFFF7, 32'hFFFFFFFF, 32'd0};
    eq = '{32'hFFFFFFFD, 32'hFFFFFF5A, 32'd11, 32'h80000000, 32'hFFFFFFFF};
    er = '{32'd1, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd0, 32'hFFFFFFF9};
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      if (c >= 4) begin
        checks++; if (out_valid !== 1'b1) $display("FAIL signed_vld[%0d]: got %b want 1", c - 4, out_valid); else passed++;
        checks++; if (out_quotient !== eq[c-4]) $display("FAIL signed_q[%0d]: got %h want %h", c - 4, out_quotient, eq[c-4]); else passed++;
        checks++; if (out_remainder !== er[c-4]) $display("FAIL signed_r[%0d]: got %h want %h", c - 4, out_remainder, er[c-4]); else passed++;
      end
      if (c < 5) drive(1'b1, a[c], b[c]);
      else drive(1'b0, 32'd0, 32'd0);
    end
  endtask
`endif

  task automatic test_bubbles();
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c == 4) begin
        checks++; if (out_valid !== 1'b1) $display("FAIL bub0_vld: got %b want 1", out_valid); else passed++;
        checks++; if (out_quotient !== 32'd7) $display("FAIL bub0_q: got %h want %h", out_quotient, 32'd7); else passed++;
        checks++; if (out_remainder !== 32'd2) $display("FAIL bub0_r: got %h want %h", out_remainder, 32'd2); else passed++;
      end
      if (c == 5) begin
        checks++; if (out_valid !== 1'b0) $display("FAIL bub1_vld: got %b want 0", out_valid); else passed++;
        checks++; if (out_quotient !== 32'd7) $display("FAIL bub1_hold_q: got %h want %h", out_quotient, 32'd7); else passed++;
        checks++; if (out_remainder !== 32'd2) $display("FAIL bub1_hold_r: got %h want %h", out_remainder, 32'd2); else passed++;
      end
      if (c == 6) begin
        checks++; if (out_valid !== 1'b1) $display("FAIL bub2_vld: got %b want 1", out_valid); else passed++;
        checks++; if (out_quotient !== 32'd100) $display("FAIL bub2_q: got %h want %h", out_quotient, 32'd100); else passed++;
        checks++; if (out_remainder !== 32'd0) $display("FAIL bub2_r: got %h want %h", out_remainder, 32'd0); else passed++;
      end
      if (c == 0) drive(1'b1, 32'd30, 32'd4);
      else if (c == 2) drive(1'b1, 32'd1000, 32'd10);
      else drive(1'b0, 32'd0, 32'd0);
    end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] a [3];
    logic [31:0] b [3];
    a = '{32'd30, 32'd100, 32'd10};
    b = '{32'd4, 32'd7, 32'd1};
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      drive(1'b1, a[c], b[c]);
    end
    @(negedge clk);
    drive(1'b0, 32'd0, 32'd0);
    // Outputs still hold 100 R 0 here; three operations occupy stages 1..3.
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) $display("FAIL midrst_vld: got %b want 0", out_valid); else passed++;
    checks++; if (out_quotient !== 32'd0) $display("FAIL midrst_q: got %h want 0", out_quotient); else passed++;
    checks++; if (out_remainder !== 32'd0) $display("FAIL midrst_r: got %h want 0", out_remainder); else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) $display("FAIL midrst_stale_vld[%0d]: got %b want 0", c, out_valid); else passed++;
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 4) begin
        checks++; if (out_valid !== 1'b1) $display("FAIL recover_vld: got %b want 1", out_valid); else passed++;
        checks++; if (out_quotient !== 32'd10) $display("FAIL recover_q: got %h want %h", out_quotient, 32'd10); else passed++;
        checks++; if (out_remainder !== 32'd0) $display("FAIL recover_r: got %h want %h", out_remainder, 32'd0); else passed++;
      end
      if (c == 0) drive(1'b1, 32'hA, 32'h1);
      else drive(1'b0, 32'd0, 32'd0);
    end
  endtask

  initial begin
    test_reset_state();
    test_basic();
`ifndef DIVIDER_SIGNED_EN
    test_pipelined();
    test_boundary();
`else
    test_signed();
`endif
    test_bubbles();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
